// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit execute stage: opcodes, ALU modes,
// controller states and instruction field positions.
package cpu_pkg;

  localparam int WIDTH = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd9;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_CMP = 4'd2;
  localparam logic [3:0] MODE_AND = 4'd3;
  localparam logic [3:0] MODE_OR  = 4'd4;
  localparam logic [3:0] MODE_XOR = 4'd5;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_WB
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_XOR);
  endfunction

  function automatic logic [3:0] alu_mode_of(input logic [3:0] opc);
    logic [3:0] mode;
    mode = MODE_ADD;
    case (opc)
      OP_SUB:  mode = MODE_SUB;
      OP_CMP:  mode = MODE_CMP;
      OP_AND:  mode = MODE_AND;
      OP_OR:   mode = MODE_OR;
      OP_XOR:  mode = MODE_XOR;
      default: mode = MODE_ADD;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Fetch-to-execute instruction byte channel.
// Valid/ready: a byte transfers on a rising edge where instr_valid and
// instr_ready are both 1; instr_ready never depends on instr_valid.
interface alu_exec_ctrl_if;
  import cpu_pkg::*;

  logic             instr_valid;
  logic [WIDTH-1:0] instr_data;
  logic             instr_ready;

  modport master (output instr_valid, output instr_data, input instr_ready);
  modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/regfile4x8.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, cleared by the asynchronous reset.
module regfile4x8 #(
  parameter int NREGS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [NREGS];

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: decodes instruction bytes, drives the ALU,
// and writes results and Z/C flags back to architectural state.
module alu_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_exec_ctrl_if.slave   fetch,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             flag_z,
  output logic             flag_c,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             err,
  output state_t           dbg_state
);

  state_t           state, state_next;
  logic [7:0]       ir;
  logic [3:0]       opc;
  logic [1:0]       rd, rs;
  logic [WIDTH-1:0] rd_val, rs_val;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wd;
  logic             ready;

  assign opc       = ir[OPC_MSB:OPC_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign dbg_state = state;
  assign fetch.instr_ready = ready;

  regfile4x8 #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rd),
    .rdata_a (rd_val),
    .raddr_b (rs),
    .rdata_b (rs_val),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    rf_we      = 1'b0;
    rf_wd      = alu_out;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (fetch.instr_valid) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu_op(opc)) begin
          state_next = S_EXEC;
        end else if (opc == OP_LDI) begin
          state_next = S_IMM;
        end else begin
          rf_we      = (opc == OP_MOV);
          rf_wd      = rs_val;
          state_next = S_IDLE;
        end
      end
      S_IMM: begin
        ready = 1'b1;
        rf_wd = fetch.instr_data;
        if (fetch.instr_valid) begin
          rf_we      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_EXEC: state_next = S_WB;
      S_WB: begin
        // CMP only updates flags; every other ALU op writes rd.
        rf_we      = (opc != OP_CMP);
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_mode  <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      if (state == S_IDLE && fetch.instr_valid) ir <= fetch.instr_data;
      if (state == S_DECODE) begin
        if (is_alu_op(opc)) begin
          alu_in1  <= rd_val;
          alu_in2  <= rs_val;
          alu_mode <= alu_mode_of(opc);
        end
        if (opc == OP_OUT) begin
          out_data  <= rs_val;
          out_valid <= 1'b1;
        end
        if (opc > OP_OUT) err <= 1'b1;
      end
      if (state == S_WB) begin
        case (opc)
          OP_ADD, OP_SUB: begin
            flag_c <= alu_carry;
            flag_z <= (alu_out == '0);
          end
          OP_CMP: begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
          end
          default: begin
            flag_c <= 1'b0;
            flag_z <= (alu_out == '0);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU, vector table, corner-case
// sequences and randomized instructions against an architectural model.
module tb_alu_exec_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_in1, alu_in2, alu_out, out_data;
  logic [3:0] alu_mode;
  logic       alu_zero, alu_carry, flag_z, flag_c, out_valid, err;
  state_t     dbg_state;

  alu_exec_ctrl_if fetch_if ();

  alu_exec_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch_if.slave),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU driving the controller's result inputs.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_mode)
      4'd0:       {alu_carry, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      4'd1, 4'd2: begin alu_out = alu_in1 - alu_in2; alu_carry = (alu_in1 < alu_in2); end
      4'd3:       alu_out = alu_in1 & alu_in2;
      4'd4:       alu_out = alu_in1 | alu_in2;
      4'd5:       alu_out = alu_in1 ^ alu_in2;
      default:    alu_out = '0;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  int err_cnt = 0;
  logic [7:0] ov_data = '0;
  logic prev_ov = 1'b0;
  logic prev_er = 1'b0;

  logic [7:0] mdl_r [4];
  logic       mdl_z, mdl_c;
  logic [7:0] mdl_od;

  typedef struct {
    logic [7:0]  ins;
    logic [7:0]  imm;
    logic [31:0] regs;
    logic        z;
    logic        c;
    logic        ov;
    logic        er;
    logic [7:0]  od;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_regs();
    return {u_dut.u_rf.regs[3], u_dut.u_rf.regs[2], u_dut.u_rf.regs[1], u_dut.u_rf.regs[0]};
  endfunction

  // Pulse monitor: counts pulses and flags any pulse longer than one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        ov_cnt++;
        ov_data = out_data;
        checks++;
        if (prev_ov) begin failures++; $display("FAIL out_valid_width: got 2+ cycles expected 1"); end
      end
      if (err) begin
        err_cnt++;
        checks++;
        if (prev_er) begin failures++; $display("FAIL err_width: got 2+ cycles expected 1"); end
      end
    end
    prev_ov = out_valid;
    prev_er = err;
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl_r[i] = '0;
    mdl_z = 1'b0; mdl_c = 1'b0; mdl_od = '0;
  endtask

  task automatic model_apply(input logic [7:0] ins, input logic [7:0] imm,
                             output logic e_ov, output logic e_er);
    logic [3:0] op;
    int         rd, rs;
    logic [7:0] a, b;
    logic [8:0] s;
    op = ins[7:4]; rd = int'(ins[3:2]); rs = int'(ins[1:0]);
    a = mdl_r[rd]; b = mdl_r[rs];
    e_ov = 1'b0; e_er = 1'b0;
    if (op >= 4'd10) e_er = 1'b1;
    else case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; mdl_r[rd] = s[7:0]; mdl_c = s[8]; mdl_z = (s[7:0] == 0); end
      4'd2: begin mdl_r[rd] = a - b; mdl_c = (a < b); mdl_z = (a == b); end
      4'd3: begin mdl_c = (a < b); mdl_z = (a == b); end
      4'd4: begin mdl_r[rd] = a & b; mdl_c = 1'b0; mdl_z = ((a & b) == 0); end
      4'd5: begin mdl_r[rd] = a | b; mdl_c = 1'b0; mdl_z = ((a | b) == 0); end
      4'd6: begin mdl_r[rd] = a ^ b; mdl_c = 1'b0; mdl_z = ((a ^ b) == 0); end
      4'd7: mdl_r[rd] = imm;
      4'd8: mdl_r[rd] = b;
      4'd9: begin e_ov = 1'b1; mdl_od = b; end
      default: ;
    endcase
  endtask

  task automatic compare_state(input logic [7:0] ins, input logic e_ov, input logic e_er);
    logic [3:0] op;
    op = ins[7:4];
    check("regs", dut_regs(), {mdl_r[3], mdl_r[2], mdl_r[1], mdl_r[0]});
    check("flag_z", flag_z, mdl_z);
    check("flag_c", flag_c, mdl_c);
    check("out_valid_count", ov_cnt, e_ov ? 1 : 0);
    check("err_count", err_cnt, e_er ? 1 : 0);
    check("out_data", out_data, mdl_od);
    if (e_ov) check("out_data_at_pulse", ov_data, mdl_od);
    if (op >= 4'd1 && op <= 4'd6) check("alu_mode", alu_mode, op - 4'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    fetch_if.instr_valid = 1'b1;
    fetch_if.instr_data  = b;
    n = 0;
    while (!fetch_if.instr_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no ready expected ready within 50 cycles");
    end
    @(posedge clk);
    #1 fetch_if.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state != S_IDLE && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got state %0d expected IDLE", dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] ins, input logic [7:0] imm, input int gap);
    logic e_ov, e_er;
    ov_cnt = 0; err_cnt = 0;
    send_byte(ins, gap);
    if (ins[7:4] == 4'd7) send_byte(imm, gap);
    wait_idle();
    model_apply(ins, imm, e_ov, e_er);
    compare_state(ins, e_ov, e_er);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic e_ov, e_er;
    vecs[0]  = '{8'h74, 8'hF0, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{8'h78, 8'h20, 32'h0020F000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{8'h16, 8'h00, 32'h00201000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{8'h74, 8'h05, 32'h00200500, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{8'h78, 8'h05, 32'h00050500, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{8'h26, 8'h00, 32'h00050000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{8'h36, 8'h00, 32'h00050000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{8'h74, 8'h3C, 32'h00053C00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{8'h8D, 8'h00, 32'h3C053C00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'h93, 8'h00, 32'h3C053C00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[10] = '{8'hF0, 8'h00, 32'h3C053C00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[11] = '{8'h4E, 8'h00, 32'h04053C00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[12] = '{8'h5B, 8'h00, 32'h04053C00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[13] = '{8'h65, 8'h00, 32'h04050000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[14] = '{8'h00, 8'h00, 32'h04050000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};

    // Reset and reset values
    fetch_if.instr_valid = 1'b0;
    fetch_if.instr_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_ready", fetch_if.instr_ready, 1'b1);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_regs", dut_regs(), 32'h0);
    check("rst_alu_ops", {alu_in1, alu_in2, alu_mode}, 20'h0);
    check("rst_outs", {flag_z, flag_c, out_data, out_valid, err}, 12'h0);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].ins, vecs[i].imm, i % 3);
      check("vec_regs", dut_regs(), vecs[i].regs);
      check("vec_flags", {flag_z, flag_c}, {vecs[i].z, vecs[i].c});
      check("vec_pulses", {ov_cnt[0], err_cnt[0]}, {vecs[i].ov, vecs[i].er});
      check("vec_out_data", out_data, vecs[i].od);
    end

    // ADD writeback lands exactly 3 edges after the handshake
    run_instr(8'h74, 8'hF0, 0);
    run_instr(8'h78, 8'h20, 0);
    @(negedge clk);
    fetch_if.instr_valid = 1'b1;
    fetch_if.instr_data  = 8'h16;
    @(posedge clk);
    #1 fetch_if.instr_valid = 1'b0;
    check("add_n_ready", fetch_if.instr_ready, 1'b0);
    @(posedge clk); #1;
    check("add_n1_operands", {alu_mode, alu_in1, alu_in2}, {4'd0, 8'hF0, 8'h20});
    check("add_n1_ready", fetch_if.instr_ready, 1'b0);
    @(posedge clk); #1;
    check("add_n2_r1_unchanged", u_dut.u_rf.regs[1], 8'hF0);
    check("add_n2_ready", fetch_if.instr_ready, 1'b0);
    @(posedge clk); #1;
    check("add_n3_r1", u_dut.u_rf.regs[1], 8'h10);
    check("add_n3_flags", {flag_z, flag_c}, 2'b01);
    check("add_n3_ready", fetch_if.instr_ready, 1'b1);
    model_apply(8'h16, 8'h00, e_ov, e_er);

    // LDI waits in IMM while the immediate is withheld
    @(negedge clk);
    fetch_if.instr_valid = 1'b1;
    fetch_if.instr_data  = 8'h7C;
    @(posedge clk);
    #1 fetch_if.instr_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("imm_wait_state", dbg_state, S_IMM);
      check("imm_wait_ready", fetch_if.instr_ready, 1'b1);
      @(posedge clk); #1;
    end
    ov_cnt = 0; err_cnt = 0;
    send_byte(8'hAA, 0);
    wait_idle();
    model_apply(8'h7C, 8'hAA, e_ov, e_er);
    check("imm_r3", u_dut.u_rf.regs[3], 8'hAA);
    compare_state(8'h7C, e_ov, e_er);

    // Illegal opcode: one err pulse, next accept two cycles after handshake
    ov_cnt = 0; err_cnt = 0;
    @(negedge clk);
    fetch_if.instr_valid = 1'b1;
    fetch_if.instr_data  = 8'hF5;
    @(posedge clk);
    #1 fetch_if.instr_valid = 1'b0;
    check("ill_n_ready", fetch_if.instr_ready, 1'b0);
    @(posedge clk); #1;
    check("ill_n1_ready", fetch_if.instr_ready, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    model_apply(8'hF5, 8'h00, e_ov, e_er);
    compare_state(8'hF5, e_ov, e_er);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [7:0] ins;
      op  = 4'($urandom_range(0, 11));
      ins = {op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      run_instr(ins, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
    end

    // Reset asserted mid-EXEC aborts the instruction
    run_instr(8'h70, 8'h55, 0);
    run_instr(8'h91, 8'h00, 0);
    @(negedge clk);
    fetch_if.instr_valid = 1'b1;
    fetch_if.instr_data  = 8'h12;
    @(posedge clk);
    #1 fetch_if.instr_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_exec_state", dbg_state, S_EXEC);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", fetch_if.instr_ready, 1'b1);
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_regs", dut_regs(), 32'h0);
    check("mid_rst_alu_ops", {alu_in1, alu_in2, alu_mode}, 20'h0);
    check("mid_rst_outs", {flag_z, flag_c, out_data, out_valid, err}, 12'h0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    run_instr(8'h1A, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller for the 8-bit datapath. It sits directly upstream of the ALU and owns the architectural state around it: a 4 x 8-bit register file and the Z/C flags register. It accepts 8-bit instructions from the fetch stage over a valid/ready handshake, decodes them, and drives the ALU operand and mode inputs. It then captures the ALU result and flags and writes them back.

## Interface
Parameters:
- NREGS, 4, register-file depth; fixed by the 2-bit register fields.
- WIDTH, 8, datapath width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  fetch presents a byte on instr_data.
- instr_data  in  8  instruction byte, or the immediate byte after LDI.
- instr_ready  out  1  controller accepts a byte this cycle.
- alu_in1  out  8  ALU operand A, equal to R[rd]; registered.
- alu_in2  out  8  ALU operand B, equal to R[rs]; registered.
- alu_mode  out  4  ALU mode; registered.
- alu_out  in  8  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry/borrow flag.
- flag_z  out  1  architectural zero flag.
- flag_c  out  1  architectural carry flag.
- out_data  out  8  value driven by an OUT instruction.
- out_valid  out  1  one-cycle pulse qualifying out_data.
- err  out  1  one-cycle pulse on an illegal opcode.

## Operation
- Instruction format: [7:4] opcode, [3:2] rd, [1:0] rs.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 CMP, 4 AND, 5 OR, 6 XOR.
  - 7 LDI: the next accepted byte is written to R[rd].
  - 8 MOV: R[rd] <= R[rs].
  - 9 OUT: out_data <= R[rs].
  - 10-15: illegal.
- ALU mode mapping: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5.
- FSM states: IDLE, DECODE, IMM, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On handshake, latch the instruction and go to DECODE.
- DECODE:
  - ALU opcodes: load alu_in1, alu_in2 and alu_mode, then go to EXEC.
  - LDI: go to IMM.
  - MOV: write R[rd], then go to IDLE.
  - OUT: load out_data, pulse out_valid, then go to IDLE.
  - NOP: go to IDLE.
  - Illegal: pulse err, go to IDLE; no state change.
- IMM:
  - instr_ready=1.
  - On handshake, R[rd] <= instr_data, go to IDLE.
  - Waits indefinitely while instr_valid=0.
- EXEC: ALU inputs are held stable for one settle cycle, then go to WB.
- WB: sample alu_out and the ALU flags, then go to IDLE. Writeback and flag rules:
  - ADD/SUB: R[rd] <= alu_out; flag_c <= alu_carry; flag_z <= (alu_out==0), computed locally.
  - AND/OR/XOR: R[rd] <= alu_out; flag_c <= 0; flag_z <= (alu_out==0).
  - CMP: no register write; flag_z <= alu_zero; flag_c <= alu_carry.
- Only ALU ops modify flags. LDI, MOV and OUT leave flags unchanged.
- rd==rs is legal. Operands are read before writeback, so SUB R1,R1 gives 0 with Z=1 and C=0.
- All arithmetic is 8-bit with wrap-around; the carry comes solely from the ALU.

## Timing
- Reset values:
  - State: IDLE.
  - instr_ready=1.
  - R0-R3 = 0.
  - alu_in1, alu_in2, alu_mode = 0.
  - flag_z, flag_c, out_data, out_valid, err = 0.
- Reset asserted mid-instruction aborts it immediately; there is no partial writeback.
- Handshake completes on a clock edge where instr_valid and instr_ready are both 1.
- instr_ready is 0 in DECODE, EXEC and WB.
- instr_ready is combinational from state only, never from instr_valid.
- ALU op: handshake at edge N, DECODE at N+1, EXEC at N+2, WB at N+3. The register and flags update at edge N+3; the next accept is possible at N+4.
- MOV/OUT/NOP/illegal: 2-cycle occupancy. out_valid and err pulse in the cycle after the DECODE edge.
- LDI: minimum 3 cycles; the immediate is accepted at the earliest at N+2.
- out_valid and err are never high for more than one cycle.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants.
  - ALU mode constants, also consumed by the ALU.
  - FSM state enum.
  - Instruction field slice positions.
- Sub-module `regfile4x8`:
  - Two asynchronous read ports and one synchronous write port.
  - Asynchronous reset to zero.
- FSM, decode and flag logic live in the top module.

## Test plan
- Reset mid-EXEC: after reset, all outputs and registers read 0 and instr_ready=1.
- LDI R1,0xF0 then LDI R2,0x20 then ADD R1,R2: R1=0x10, flag_c=1, flag_z=0. The register and flags update exactly 3 edges after the ADD handshake.
- R1=0x05, R2=0x05, SUB R1,R2 then CMP R1,R2: after SUB, R1=0x00 with Z=1, C=0. CMP R1,R2 then compares R1=0x00 against R2=0x05, so it drives alu_mode=2, sets flag_c=1, leaves R1 unchanged, and takes Z from alu_zero.
- LDI opcode followed by instr_valid=0 for 5 cycles, then 0xAA: FSM stays in IMM with instr_ready=1, then R[rd]=0xAA.
- MOV R3,R1 then OUT R3: out_data equals R1 with a single-cycle out_valid pulse; flags are unchanged.
- Opcode 0xF: a single err pulse, no register or flag change, and the next instruction is accepted 2 cycles after the handshake.
